// File: rtl/quadrature_generator_if.sv
// quadrature_generator_if: command and encoder-output bundle for quadrature_generator.
// The detent output exists only when QUAD_DETENT_EN is defined.
interface quadrature_generator_if #(parameter int COUNT_W = 8, PERIOD_W = 16, POS_W = 7);
    logic               cmd_valid;
    logic               cmd_ready;
    logic               cmd_dir;
    logic [COUNT_W-1:0] cmd_count;
    logic [PERIOD_W-1:0] cfg_period;
    logic               abort;
    logic               A;
    logic               B;
    logic               busy;
    logic               done;
    logic [POS_W-1:0]   position;
`ifdef QUAD_DETENT_EN
    logic [POS_W-3:0]   detent;
    modport master (output cmd_valid, cmd_dir, cmd_count, cfg_period, abort,
                    input cmd_ready, A, B, busy, done, position, detent);
    modport slave (input cmd_valid, cmd_dir, cmd_count, cfg_period, abort,
                   output cmd_ready, A, B, busy, done, position, detent);
`else
    modport master (output cmd_valid, cmd_dir, cmd_count, cfg_period, abort,
                    input cmd_ready, A, B, busy, done, position);
    modport slave (input cmd_valid, cmd_dir, cmd_count, cfg_period, abort,
                   output cmd_ready, A, B, busy, done, position);
`endif
endinterface

// File: rtl/quadrature_generator.sv
// quadrature_generator: emits N Gray-coded A/B edges per command at a programmable spacing and tracks position.
// QUAD_DETENT_EN: cmd_count is in detents (4 edges each) and a detent output (position >> 2) is added.
module quadrature_generator #(
    parameter int COUNT_W  = 8,
    parameter int PERIOD_W = 16,
    parameter int POS_W    = 7
) (
    input logic clk,
    input logic reset,
    quadrature_generator_if.slave q
);
`ifdef QUAD_DETENT_EN
    localparam int REM_W = COUNT_W + 2;
    logic [REM_W-1:0] load_rem;
    assign load_rem = {q.cmd_count, 2'b00};
    assign q.detent = q.position[POS_W-1:2];
`else
    localparam int REM_W = COUNT_W;
    logic [REM_W-1:0] load_rem;
    assign load_rem = q.cmd_count;
`endif
    typedef enum logic {IDLE, RUN} state_t;
    state_t state;
    logic dir;
    logic [REM_W-1:0] remaining;
    logic [PERIOD_W-1:0] period, timer, p_ld;
    logic [1:0] idx, idx_nxt;
    // phase index recovered from the A/B registers themselves: 00,01,11,10 -> 0..3
    assign idx = {q.A, q.A ^ q.B};
    assign idx_nxt = dir ? idx + 2'd1 : idx - 2'd1;
    assign p_ld = q.cfg_period == '0 ? PERIOD_W'(1) : q.cfg_period;
    assign q.cmd_ready = ~q.busy;
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            q.A        <= 1'b0;
            q.B        <= 1'b0;
            q.position <= '0;
            q.busy     <= 1'b0;
            q.done     <= 1'b0;
            dir        <= 1'b0;
            remaining  <= '0;
            period     <= '0;
            timer      <= '0;
        end else begin
            q.done <= 1'b0;
            if (state == IDLE) begin
                if (q.cmd_valid && !q.abort) begin
                    state     <= RUN;
                    q.busy    <= 1'b1;
                    dir       <= q.cmd_dir;
                    remaining <= load_rem;
                    period    <= p_ld;
                    timer     <= p_ld;
                end
            end else if (q.abort) begin
                state  <= IDLE;
                q.busy <= 1'b0;
            end else if (remaining == '0) begin
                state  <= IDLE;
                q.busy <= 1'b0;
                q.done <= 1'b1;
            end else if (timer == PERIOD_W'(1)) begin
                q.A        <= idx_nxt[1];
                q.B        <= idx_nxt[1] ^ idx_nxt[0];
                q.position <= dir ? q.position + POS_W'(1) : q.position - POS_W'(1);
                remaining  <= remaining - REM_W'(1);
                timer      <= period;
                if (remaining == REM_W'(1)) begin
                    state  <= IDLE;
                    q.busy <= 1'b0;
                    q.done <= 1'b1;
                end
            end else begin
                timer <= timer - PERIOD_W'(1);
            end
        end
    end
endmodule
